// File: rtl/nqcpu_defs_pkg.sv
// Control-word field offsets shared with the ALU stage, plus the mem-stage state
// encoding and small decode helpers for the latched control word.
package nqcpu_defs_pkg;

  localparam int CW_W          = 42;
  localparam int DATA_OUT_MSB  = 41;
  localparam int DATA_OUT_LSB  = 26;
  localparam int REG_WRITE_MSB = 25;
  localparam int REG_WRITE_LSB = 24;
  localparam int REG_DEST_MSB  = 23;
  localparam int REG_DEST_LSB  = 21;
  localparam int SETPC_BIT     = 20;
  localparam int MEM_READ_MSB  = 19;
  localparam int MEM_READ_LSB  = 18;
  localparam int MEM_WRITE_MSB = 17;
  localparam int MEM_WRITE_LSB = 16;
  localparam int MEM_ADDR_MSB  = 15;
  localparam int MEM_ADDR_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_WB    = 2'd3
  } memState_t;

  typedef struct packed {
    logic [15:0] dataOut;
    logic [1:0]  regWrite;   // {H, L}
    logic [2:0]  regDest;
    logic        setPc;
    logic [1:0]  memRead;    // {word, read}
    logic [1:0]  memWrite;   // {word, write}
    logic [15:0] memAddr;
  } ctrlWord_t;

  function automatic ctrlWord_t unpackCtrl(input logic [CW_W-1:0] raw);
    ctrlWord_t cw;
    cw.dataOut  = raw[DATA_OUT_MSB:DATA_OUT_LSB];
    cw.regWrite = raw[REG_WRITE_MSB:REG_WRITE_LSB];
    cw.regDest  = raw[REG_DEST_MSB:REG_DEST_LSB];
    cw.setPc    = raw[SETPC_BIT];
    cw.memRead  = raw[MEM_READ_MSB:MEM_READ_LSB];
    cw.memWrite = raw[MEM_WRITE_MSB:MEM_WRITE_LSB];
    cw.memAddr  = raw[MEM_ADDR_MSB:MEM_ADDR_LSB];
    return cw;
  endfunction

  function automatic logic needsMem(input ctrlWord_t cw);
    return cw.memWrite[0] | cw.memRead[0];
  endfunction

  function automatic logic isStore(input ctrlWord_t cw);
    return cw.memWrite[0];
  endfunction

  // A store wins over a simultaneous load, so load data is only used when no store is set.
  function automatic logic isLoad(input ctrlWord_t cw);
    return cw.memRead[0] & ~cw.memWrite[0];
  endfunction

  function automatic logic isWord(input ctrlWord_t cw);
    return isStore(cw) ? cw.memWrite[1] : cw.memRead[1];
  endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory-access / writeback stage: byte or two-beat little-endian word accesses
// over an 8-bit req/ack bus, then a single-cycle register-file / PC writeback.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for en; control word latched on start
// ST_BEAT0 | low byte beat at addr, req held until ack
// ST_BEAT1 | high byte beat at addr+1 (wraps), word accesses only
// ST_WB    | one-cycle writeback, done pulse
module mem_stage
  import nqcpu_defs_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [CW_W-1:0] control_signals_in,
  output logic [15:0]     mem_addr,
  output logic [7:0]      mem_wdata,
  input  logic [7:0]      mem_rdata,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  output logic [2:0]      rf_wrDest,
  output logic [15:0]     rf_wrData,
  output logic            rf_wrH,
  output logic            rf_wrL,
  output logic            pc_set,
  output logic [15:0]     pc_data,
  output logic            busy,
  output logic            done
);

  memState_t  state;
  ctrlWord_t  ctrl;
  ctrlWord_t  cwIn;
  ctrlWord_t  wbCw;
  logic [7:0] loByte;
  logic [15:0] loaded;
  logic [15:0] wbData;
  logic        goWb;

  assign cwIn = unpackCtrl(control_signals_in);

  // Next-cycle writeback values; outputs themselves are registered below.
  always_comb begin
    wbCw   = ctrl;
    loaded = {8'h00, mem_rdata};
    goWb   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        wbCw = cwIn;
        goWb = en & ~needsMem(cwIn);
      end
      ST_BEAT0: goWb = mem_ack & ~isWord(ctrl);
      ST_BEAT1: begin
        loaded = {mem_rdata, loByte};
        goWb   = mem_ack;
      end
      default: goWb = 1'b0;
    endcase
    wbData = isLoad(wbCw) ? loaded : wbCw.dataOut;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ctrl      <= '0;
      loByte    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      rf_wrDest <= '0;
      rf_wrData <= '0;
      rf_wrH    <= 1'b0;
      rf_wrL    <= 1'b0;
      pc_set    <= 1'b0;
      pc_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done   <= 1'b0;
      rf_wrH <= 1'b0;
      rf_wrL <= 1'b0;
      pc_set <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (en) begin
            ctrl <= cwIn;
            busy <= 1'b1;
            if (needsMem(cwIn)) begin
              state     <= ST_BEAT0;
              mem_req   <= 1'b1;
              mem_we    <= isStore(cwIn);
              mem_addr  <= cwIn.memAddr;
              mem_wdata <= cwIn.dataOut[7:0];
            end else begin
              state <= ST_WB;
            end
          end
        end
        ST_BEAT0: begin
          if (mem_ack) begin
            loByte <= mem_rdata;
            if (isWord(ctrl)) begin
              state     <= ST_BEAT1;
              mem_addr  <= ctrl.memAddr + 16'd1;
              mem_wdata <= ctrl.dataOut[15:8];
            end else begin
              state <= ST_WB;
            end
          end
        end
        ST_BEAT1: begin
          if (mem_ack) state <= ST_WB;
        end
        ST_WB: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          rf_wrDest <= '0;
          rf_wrData <= '0;
          pc_data   <= '0;
        end
        default: state <= ST_IDLE;
      endcase

      if (goWb) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
        rf_wrDest <= wbCw.regDest;
        rf_wrData <= wbData;
        rf_wrH    <= wbCw.regWrite[1];
        rf_wrL    <= wbCw.regWrite[0];
        pc_set    <= wbCw.setPc;
        pc_data   <= wbData;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a negedge-driven memory responder with
// configurable wait states, and hand-computed writeback/beat expectations.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [41:0] cw = '0;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  rf_wrDest;
  logic [15:0] rf_wrData;
  logic        rf_wrH;
  logic        rf_wrL;
  logic        pc_set;
  logic [15:0] pc_data;
  logic        busy;
  logic        done;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .en(en), .control_signals_in(cw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .rf_wrDest(rf_wrDest), .rf_wrData(rf_wrData), .rf_wrH(rf_wrH), .rf_wrL(rf_wrL),
    .pc_set(pc_set), .pc_data(pc_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          waitCfg = 0;
  int          waitCnt = 0;
  int          beatIdx = 0;
  int          doneSeen = 0;
  logic [7:0]  rdBytes [2];
  logic [15:0] beatAddr [4];
  logic [7:0]  beatWdata [4];
  logic        beatWe [4];

  // Responder: acks after waitCfg idle cycles; an ack lasts exactly one cycle.
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
      waitCnt = 0;
    end
    if (mem_req === 1'b1 && rst_n) begin
      if (waitCnt >= waitCfg) begin
        mem_ack   = 1'b1;
        mem_rdata = rdBytes[beatIdx % 2];
        if (beatIdx < 4) begin
          beatAddr[beatIdx]  = mem_addr;
          beatWdata[beatIdx] = mem_wdata;
          beatWe[beatIdx]    = mem_we;
        end
        beatIdx++;
      end else begin
        waitCnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] mk(input logic [15:0] d, input logic [1:0] rw,
                                     input logic [2:0] dst, input logic spc,
                                     input logic [1:0] mr, input logic [1:0] mw,
                                     input logic [15:0] a);
    return {d, rw, dst, spc, mr, mw, a};
  endfunction

  task automatic resetResp(input int w, input logic [7:0] b0, input logic [7:0] b1);
    waitCfg    = w;
    waitCnt    = 0;
    beatIdx    = 0;
    rdBytes[0] = b0;
    rdBytes[1] = b1;
  endtask

  // Called at a negedge; en is high for cycle T, returns at the negedge of T+1.
  task automatic startOp(input logic [41:0] word);
    cw = word;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int startCyc, input int expLat);
    int cyc;
    cyc = startCyc;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, expLat);
  endtask

  initial begin
    resetResp(0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wr", {rf_wrH, rf_wrL, rf_wrDest}, 0);
    check("rst_wrData", rf_wrData, 0);
    check("rst_pc", {pc_set, pc_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Non-memory op
    resetResp(0, 8'h00, 8'h00);
    startOp(mk(16'h1234, 2'b11, 3'd3, 1'b0, 2'b00, 2'b00, 16'h0000));
    waitDone("nomem", 1, 1);
    check("nomem_wrHL", {rf_wrH, rf_wrL}, 2'b11);
    check("nomem_dest", rf_wrDest, 3);
    check("nomem_data", rf_wrData, 16'h1234);
    check("nomem_pcset", pc_set, 0);
    check("nomem_beats", beatIdx, 0);
    @(negedge clk);
    check("nomem_done_pulse", done, 0);
    check("nomem_wrH_off", rf_wrH, 0);
    check("nomem_idle", busy, 0);

    // Byte load, zero wait, started the cycle after done
    resetResp(0, 8'hA5, 8'h00);
    startOp(mk(16'h0000, 2'b01, 3'd5, 1'b0, 2'b01, 2'b00, 16'h0040));
    waitDone("bload", 1, 2);
    check("bload_data", rf_wrData, 16'h00A5);
    check("bload_wrHL", {rf_wrH, rf_wrL}, 2'b01);
    check("bload_dest", rf_wrDest, 5);
    check("bload_beats", beatIdx, 1);
    check("bload_addr", beatAddr[0], 16'h0040);
    check("bload_we", beatWe[0], 0);
    check("bload_req_wb", mem_req, 0);
    @(negedge clk);

    // Word store, two wait cycles per beat, address wrap
    resetResp(2, 8'h11, 8'h22);
    startOp(mk(16'hBEEF, 2'b00, 3'd0, 1'b0, 2'b00, 2'b11, 16'hFFFF));
    waitDone("wstore", 1, 7);
    check("wstore_beats", beatIdx, 2);
    check("wstore_b0", {beatAddr[0], beatWdata[0], 7'd0, beatWe[0]}, {16'hFFFF, 8'hEF, 8'h01});
    check("wstore_b1", {beatAddr[1], beatWdata[1], 7'd0, beatWe[1]}, {16'h0000, 8'hBE, 8'h01});
    check("wstore_nowr", {rf_wrH, rf_wrL, pc_set}, 0);
    @(negedge clk);

    // Word load into PC
    resetResp(0, 8'h34, 8'h12);
    startOp(mk(16'h0000, 2'b00, 3'd0, 1'b1, 2'b11, 2'b00, 16'h1000));
    waitDone("pcload", 1, 3);
    check("pcload_set", pc_set, 1);
    check("pcload_data", pc_data, 16'h1234);
    check("pcload_nowr", {rf_wrH, rf_wrL}, 0);
    check("pcload_b1addr", beatAddr[1], 16'h1001);
    @(negedge clk);
    check("pcload_set_pulse", pc_set, 0);

    // en pulsed during BEAT1 with a different control word is ignored
    resetResp(1, 8'hAB, 8'hCD);
    startOp(mk(16'h0000, 2'b10, 3'd6, 1'b0, 2'b11, 2'b00, 16'h2000));
    @(negedge clk);
    @(negedge clk);
    check("enbusy_b1addr", mem_addr, 16'h2001);
    check("enbusy_b1req", mem_req, 1);
    cw = mk(16'hFFFF, 2'b11, 3'd1, 1'b1, 2'b00, 2'b00, 16'h0000);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    waitDone("enbusy", 4, 5);
    check("enbusy_data", rf_wrData, 16'hCDAB);
    check("enbusy_dest", rf_wrDest, 6);
    check("enbusy_wrHL", {rf_wrH, rf_wrL}, 2'b10);
    check("enbusy_pcset", pc_set, 0);
    @(negedge clk);
    check("enbusy_no_restart", busy, 0);

    // Read and write both set: store wins, data_out written back
    resetResp(0, 8'h99, 8'h00);
    startOp(mk(16'h5566, 2'b01, 3'd2, 1'b0, 2'b01, 2'b01, 16'h0010));
    waitDone("rw", 1, 2);
    check("rw_data", rf_wrData, 16'h5566);
    check("rw_beat", {beatAddr[0], beatWdata[0], 7'd0, beatWe[0]}, {16'h0010, 8'h66, 8'h01});
    @(negedge clk);

    // Reset during BEAT0 wait
    resetResp(5, 8'h77, 8'h00);
    startOp(mk(16'h0000, 2'b01, 3'd1, 1'b0, 2'b01, 2'b00, 16'h0080));
    check("rstmid_req_before", mem_req, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_req", mem_req, 0);
    check("rstmid_busy", busy, 0);
    rst_n = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    check("rstmid_no_done", doneSeen, 0);

    // Recovery after reset
    resetResp(0, 8'h00, 8'h00);
    startOp(mk(16'h4321, 2'b10, 3'd7, 1'b0, 2'b00, 2'b00, 16'h0000));
    waitDone("recover", 1, 1);
    check("recover_data", {rf_wrDest, rf_wrH, rf_wrL, rf_wrData}, {3'd7, 2'b10, 16'h4321});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
